record_bank: RTL

RECORD_BANK -- requirements
Module: record_bank

---
 rtl/record_pkg.sv | 11 +
 rtl/record_bank_if.sv | 25 ++
 rtl/record_mem.sv | 23 ++
 rtl/record_bank.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/record_pkg.sv
// rtl/record_pkg.sv - shared constants and state encoding for the lap-time record bank
package record_pkg;
    localparam int TIME_W = 24;
    localparam int DEPTH  = 8;
    localparam logic [23:0] BEST_INIT = 24'hFFFFFF;

    typedef enum logic {
        LIVE   = 1'b0,
        RECALL = 1'b1
    } state_e;
endpackage

// File: rtl/record_bank_if.sv
// rtl/record_bank_if.sv - control/display bundle of the record bank
interface record_bank_if #(
    parameter int TIME_W = record_pkg::TIME_W
);
    logic [TIME_W-1:0] iTime;
    logic              iRecord;
    logic              iRecall;
    logic              iClear;
    logic [TIME_W-1:0] oTime;
    logic [3:0]        oAge;
    logic [4:0]        oCount;
    logic              oRecallMode;
    logic              oFull;
    logic [TIME_W-1:0] oBest;

    modport master (
        output iTime, iRecord, iRecall, iClear,
        input  oTime, oAge, oCount, oRecallMode, oFull, oBest
    );

    modport slave (
        input  iTime, iRecord, iRecall, iClear,
        output oTime, oAge, oCount, oRecallMode, oFull, oBest
    );
endinterface

// File: rtl/record_mem.sv
// rtl/record_mem.sv - DEPTH x TIME_W record storage, synchronous write, combinational read
module record_mem #(
    parameter int DEPTH  = record_pkg::DEPTH,
    parameter int TIME_W = record_pkg::TIME_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [TIME_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [TIME_W-1:0] rdata
);
    logic [TIME_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/record_bank.sv
// rtl/record_bank.sv - circular lap-time store with LIVE/RECALL display
// Optional best-time tracking enabled by defining RECORD_BANK_BEST_EN.
module record_bank #(
    parameter int DEPTH  = record_pkg::DEPTH,
    parameter int TIME_W = record_pkg::TIME_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [TIME_W-1:0] iTime,
    input  logic              iRecord,
    input  logic              iRecall,
    input  logic              iClear,
    output logic [TIME_W-1:0] oTime,
    output logic [3:0]        oAge,
    output logic [4:0]        oCount,
    output logic              oRecallMode,
    output logic              oFull,
    output logic [TIME_W-1:0] oBest
);
    import record_pkg::*;

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] COUNT_MAX = 5'(DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [4:0]        count_q, count_d;
    logic [3:0]        age_q, age_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              mode_q, mode_d;
    logic              full_q, full_d;
    logic              we;
    logic [AW-1:0]     rd_addr;
    logic [TIME_W-1:0] rd_data;

    record_mem #(
        .DEPTH (DEPTH),
        .TIME_W(TIME_W),
        .AW    (AW)
    ) u_mem (
        .clk  (Clk),
        .we   (we && !Rst),
        .waddr(wr_ptr_q),
        .wdata(iTime),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        age_d    = age_q;
        we       = 1'b0;
        if (iClear) begin
            state_d  = LIVE;
            wr_ptr_d = '0;
            count_d  = '0;
            age_d    = '0;
        end else begin
            if (iRecord) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + 5'd1;
                end
            end
            case (state_q)
                LIVE: begin
                    // count_d already includes a same-cycle record
                    if (iRecall && count_d != 5'd0) begin
                        state_d = RECALL;
                        age_d   = '0;
                    end
                end
                RECALL: begin
                    if (iRecord) begin
                        age_d = '0;
                    end else if (iRecall) begin
                        if (5'(age_q) == count_q - 5'd1) begin
                            state_d = LIVE;
                            age_d   = '0;
                        end else begin
                            age_d = age_q + 4'd1;
                        end
                    end
                end
                default: state_d = LIVE;
            endcase
        end

        rd_addr = wr_ptr_d - AW'(1) - age_d[AW-1:0];
        // The slot being written this edge is not in memory yet; forward it
        if (state_d == RECALL) begin
            time_d = (we && rd_addr == wr_ptr_q) ? iTime : rd_data;
        end else begin
            time_d = iTime;
        end
        mode_d = (state_d == RECALL);
        full_d = (count_d == COUNT_MAX);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= LIVE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
            time_q   <= '0;
            mode_q   <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
            time_q   <= time_d;
            mode_q   <= mode_d;
            full_q   <= full_d;
        end
    end

`ifdef RECORD_BANK_BEST_EN
    logic [TIME_W-1:0] best_q, best_d;

    always_comb begin
        best_d = best_q;
        if (iClear) begin
            best_d = TIME_W'(BEST_INIT);
        end else if (iRecord && iTime < best_q) begin
            best_d = iTime;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            best_q <= TIME_W'(BEST_INIT);
        end else begin
            best_q <= best_d;
        end
    end

    assign oBest = best_q;
`else
    assign oBest = '0;
`endif

    assign oTime       = time_q;
    assign oAge        = age_q;
    assign oCount      = count_q;
    assign oRecallMode = mode_q;
    assign oFull       = full_q;
endmodule
